// File: rtl/disp_pkg.sv
// Shared types, segment constants and BCD-to-segment decode for the display data path.
package disp_pkg;

  typedef enum logic [1:0] {
    UNITS,
    TENS,
    HUNDREDS
  } digit_t;

  // Active-high view {g,f,e,d,c,b,a}; polarity is applied at the output register.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to 3-digit BCD, one add-3/shift step per clock.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [21:0] sr_q, sr_d;
  logic [3:0]  iter_q, iter_d;
  logic [21:0] adj;
  logic [21:0] shifted;

  always_comb begin
    adj = sr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (adj[10 + 4*i +: 4] >= 4'd5) adj[10 + 4*i +: 4] = adj[10 + 4*i +: 4] + 4'd3;
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {12'd0, bin};
          iter_d  = '0;
          state_d = S_CONV;
        end
      end
      default: begin
        sr_d   = shifted;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
    end
  end

  // done strobes during the final step so the parent can capture bcd on that same edge.
  assign busy = (state_q == S_CONV);
  assign done = (state_q == S_CONV) && (iter_q == 4'd9);
  assign bcd  = shifted[21:10];

endmodule

// File: rtl/disp_segment_driver.sv
// Display data path: accepts a value, converts to BCD, and drives seg for the selected digit.
module disp_segment_driver
  import disp_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          LZB            = 1'b1,
  parameter int unsigned MAX_VALUE      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] value,
  input  logic       load,
  input  logic [2:0] anode,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic        conv_busy, conv_last;
  logic [11:0] conv_bcd;
  logic [11:0] disp_q;
  logic        ovf_q, ovf_pend_q, done_q;
  logic [6:0]  seg_q, seg_d, seg_raw;
  logic        sel_ok;
  digit_t      sel;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_last),
    .bcd   (conv_bcd)
  );

  always_comb begin
    sel    = UNITS;
    sel_ok = 1'b1;
    case (anode)
      3'b001:  sel = UNITS;
      3'b010:  sel = TENS;
      3'b100:  sel = HUNDREDS;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    seg_raw = SEG_BLANK;
    if (!sel_ok) begin
      seg_raw = SEG_BLANK;
    end else if (ovf_q) begin
      seg_raw = SEG_DASH;
    end else begin
      case (sel)
        UNITS:   seg_raw = bcd_to_seg(disp_q[3:0]);
        TENS:    seg_raw = (LZB && disp_q[11:4] == 8'd0) ? SEG_BLANK : bcd_to_seg(disp_q[7:4]);
        default: seg_raw = (LZB && disp_q[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(disp_q[11:8]);
      endcase
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

  // Overflow is latched at accept but only shown when the conversion lands, keeping the display atomic.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= SEG_OFF;
    end else begin
      done_q <= conv_last;
      seg_q  <= seg_d;
      if (load && !conv_busy) ovf_pend_q <= (32'(value) > MAX_VALUE);
      if (conv_last) begin
        disp_q <= conv_bcd;
        ovf_q  <= ovf_pend_q;
      end
    end
  end

  assign busy = conv_busy;
  assign done = done_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_disp_segment_driver.sv
// Scoreboard bench: three parameter variants share stimulus; expectations come from decimal arithmetic.
module tb_disp_segment_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [9:0] value = '0;
  logic [2:0] anode = 3'b001;

  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [6:0] seg_a, seg_b, seg_c;

  disp_segment_driver u_dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .anode(anode),
    .busy(busy_a), .done(done_a), .seg(seg_a)
  );

  disp_segment_driver #(.LZB(1'b0)) u_nolzb (
    .clk(clk), .rst(rst), .value(value), .load(load), .anode(anode),
    .busy(busy_b), .done(done_b), .seg(seg_b)
  );

  disp_segment_driver #(.SEG_ACTIVE_LOW(1'b1)) u_actlow (
    .clk(clk), .rst(rst), .value(value), .load(load), .anode(anode),
    .busy(busy_c), .done(done_c), .seg(seg_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         busy_end = 0;
  bit         rst_s = 1'b1;
  logic [2:0] anode_s = 3'b001;
  int         disp_m = 0;
  int         checks = 0;
  int         failures = 0;
  int         seg_tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  logic [2:0] anode_pool [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000};

  // v < 0 denotes the overflow display
  function automatic int exp_seg(int v, logic [2:0] a, bit lzb, bit al);
    int r;
    r = 0;
    if (a == 3'b001 || a == 3'b010 || a == 3'b100) begin
      if (v < 0) r = 'h40;
      else if (a == 3'b001) r = seg_tbl[v % 10];
      else if (a == 3'b010) r = (lzb && v < 10) ? 0 : seg_tbl[(v / 10) % 10];
      else r = (lzb && v < 100) ? 0 : seg_tbl[v / 100];
    end
    if (al) r = r ^ 'h7F;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Stimulus-side model: decides acceptance and pushes the expected completion.
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_s   = rst;
    anode_s = anode;
    if (rst) begin
      q.delete();
      busy_end = 0;
    end else if (load && cyc > busy_end) begin
      q.push_back('{int'(value), cyc + 10});
      busy_end = cyc + 10;
    end
  end

  // Monitor: compares outputs each cycle and pops the scoreboard on completion.
  initial forever begin
    int  es_a, es_b, es_c;
    bit  exp_done;
    int  newv;
    @(negedge clk);
    if (cyc > 0) begin
      if (rst_s) begin
        es_a = 0;
        es_b = 0;
        es_c = 'h7F;
      end else begin
        es_a = exp_seg(disp_m, anode_s, 1'b1, 1'b0);
        es_b = exp_seg(disp_m, anode_s, 1'b0, 1'b0);
        es_c = exp_seg(disp_m, anode_s, 1'b1, 1'b1);
      end
      chk("seg_lzb", int'(seg_a), es_a);
      chk("seg_nolzb", int'(seg_b), es_b);
      chk("seg_actlow", int'(seg_c), es_c);
      chk("busy", int'(busy_a), (cyc < busy_end) ? 1 : 0);
      chk("busy_variants", int'({busy_b, busy_c}), (cyc < busy_end) ? 3 : 0);
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", int'(done_a), int'(exp_done));
      chk("done_variants", int'({done_b, done_c}), exp_done ? 3 : 0);
      if (exp_done) begin
        newv = q[0].val;
        q.pop_front();
        disp_m = (newv > 999) ? -1 : newv;
      end
      if (rst_s) disp_m = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rot(input int n);
    for (int i = 0; i < n; i++) begin
      anode = (anode == 3'b001) ? 3'b010 : (anode == 3'b010) ? 3'b100 : 3'b001;
      step(1);
    end
  endtask

  task automatic do_load(input int v);
    load  = 1'b1;
    value = 10'(v);
    step(1);
    load  = 1'b0;
    value = 10'($urandom);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(2);
    anode = 3'b100;
    step(2);
    anode = 3'b001;
    do_load(123);
    rot(14);
    do_load(7);
    rot(14);
    do_load(123);
    step(3);
    do_load(512);
    rot(12);
    do_load(1000);
    rot(14);
    do_load(999);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rot(6);
    do_load(45);
    rot(10);
    do_load(46);
    rot(14);
    do_load(999);
    rot(14);
    anode = 3'b011;
    step(2);
    anode = 3'b111;
    step(2);
    anode = 3'b000;
    step(2);
    for (int k = 0; k < 1500; k++) begin
      load  = ($urandom_range(0, 3) == 0);
      value = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 999));
      anode = anode_pool[$urandom_range(0, 7)];
      rst   = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst  = 1'b0;
    load = 1'b0;
    rot(15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
